seq_reduce_unit: RTL



---
 rtl/seq_reduce_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/seq_reduce_unit.sv
// seq_reduce_unit: multi-cycle one-bit reduction (AND / OR / XOR / NAND) of a
// WIDTH-bit operand, folding CHUNK bits per clock between two valid/ready ports.
// Optional build macro: SEQ_REDUCE_EARLY_EXIT_EN -- when defined, AND/NAND stop
// at the first chunk containing a zero and OR stops at the first chunk containing
// a one; XOR always folds every chunk. The result bit is the same in both builds.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid && ready are both high; valid, once raised, holds with its payload
// stable until that edge, and ready may be freely asserted/deasserted.
module seq_reduce_unit #(
  parameter  int WIDTH  = 32,
  parameter  int CHUNK  = 4,
  localparam int NBEATS = WIDTH / CHUNK,
  localparam int BEAT_W = $clog2(NBEATS) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_result,
  output logic [BEAT_W-1:0] out_beats,
  output logic [1:0]        dbg_state
);

  // Parameter sanity: a partial final chunk is not supported.
  if (WIDTH < 1) begin : g_bad_width
    $error("seq_reduce_unit: WIDTH must be >= 1");
  end
  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
    $error("seq_reduce_unit: CHUNK must be >= 1 and divide WIDTH");
  end

  localparam logic [1:0] MD_AND  = 2'b00;
  localparam logic [1:0] MD_OR   = 2'b01;
  localparam logic [1:0] MD_XOR  = 2'b10;
  localparam logic [1:0] MD_NAND = 2'b11;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_sh;
  logic               r_acc;
  logic [1:0]         r_md;
  logic [BEAT_W-1:0]  r_cnt;
  logic               r_out_valid;
  logic               r_out_result;
  logic [BEAT_W-1:0]  r_out_beats;

  logic [CHUNK-1:0]   w_chunk;
  logic [WIDTH-1:0]   w_sh_next;
  logic               w_fold;
  logic               w_last;
  logic               w_exit;

  assign w_chunk = r_sh[CHUNK-1:0];
  assign w_last  = (r_cnt == LAST_BEAT);

  // When one chunk spans the whole operand there is nothing left to shift in.
  if (CHUNK == WIDTH) begin : g_sh_single
    assign w_sh_next = '0;
  end else begin : g_sh_multi
    assign w_sh_next = {{CHUNK{1'b0}}, r_sh[WIDTH-1:CHUNK]};
  end

  // Fold the current low chunk into the accumulator according to the frozen mode.
  always_comb begin
    w_fold = r_acc;
    case (r_md)
      MD_AND, MD_NAND: w_fold = r_acc & (&w_chunk);
      MD_OR:           w_fold = r_acc | (|w_chunk);
      MD_XOR:          w_fold = r_acc ^ (^w_chunk);
      default:         w_fold = r_acc;
    endcase
  end

`ifdef SEQ_REDUCE_EARLY_EXIT_EN
  // A zero makes AND/NAND final; a one makes OR final. XOR needs every bit.
  assign w_exit = w_last
                | (((r_md == MD_AND) || (r_md == MD_NAND)) && !w_fold)
                | ((r_md == MD_OR) && w_fold);
`else
  assign w_exit = w_last;
`endif

  // Control FSM with registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sh         <= '0;
      r_acc        <= 1'b0;
      r_md         <= MD_AND;
      r_cnt        <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= 1'b0;
      r_out_beats  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sh    <= in_data;
            r_md    <= in_mode;
            r_acc   <= ((in_mode == MD_OR) || (in_mode == MD_XOR)) ? 1'b0 : 1'b1;
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_acc <= w_fold;
          r_sh  <= w_sh_next;
          r_cnt <= r_cnt + BEAT_W'(1);
          if (w_exit) begin
            r_state      <= S_DONE;
            r_out_valid  <= 1'b1;
            r_out_result <= (r_md == MD_NAND) ? ~w_fold : w_fold;
            r_out_beats  <= r_cnt + BEAT_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_beats  = r_out_beats;
  assign dbg_state  = r_state;

endmodule
